// File: rtl/vga_pixel_sink_if.sv
// Pixel-write port between the display datapath (master) and the VGA sink (slave).
// One write per clock while plot is high; no back-pressure.
interface vga_pixel_sink_if;
  logic       plot;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;

  modport master (output plot, x, y, colour);
  modport slave  (input  plot, x, y, colour);
endinterface

// File: rtl/vga_pixel_sink.sv
// 320x240x3 framebuffer written one pixel per clock, scanned out as 640x480@60 VGA
// with 2x2 pixel doubling, plus a one-clock frame strobe at each scan wrap to (0,0).
module vga_pixel_sink #(
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic            clock,
  input  logic            reset,
  vga_pixel_sink_if.slave pixIf,
  output logic            oob_flag,
  output logic            frame_start,
  output logic            vga_clk,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            vga_blank_n,
  output logic            vga_sync_n,
  output logic [7:0]      vga_r,
  output logic [7:0]      vga_g,
  output logic [7:0]      vga_b
);

  localparam logic [9:0] H_MAX      = 10'(640 + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX      = 10'(480 + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_SYNC_BEG = 10'(640 + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(640 + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(480 + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(480 + V_FRONT + V_SYNC - 1);

  logic [2:0]  frameBuf [0:76799];

  logic        inRange;
  logic [16:0] plotAddr;
  logic        wrEn;
  logic [16:0] wrAddr;
  logic [2:0]  wrData;

  logic        pixEn;
  logic [9:0]  hCnt;
  logic [9:0]  vCnt;
  logic        visible;
  logic [16:0] rdAddr;
  logic [2:0]  rdData;

  assign vga_clk    = pixEn;
  assign vga_sync_n = 1'b0;

  // y*320 + x as shift-and-add, kept at full 17-bit width
  assign inRange  = (pixIf.x < 9'd320) && (pixIf.y < 8'd240);
  assign plotAddr = {1'b0, pixIf.y, 8'b0} + {3'b0, pixIf.y, 6'b0} + {8'b0, pixIf.x};

  assign visible = (hCnt < 10'd640) && (vCnt < 10'd480);
  assign rdAddr  = {1'b0, vCnt[8:1], 8'b0} + {3'b0, vCnt[8:1], 6'b0} + {8'b0, hCnt[9:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      wrEn     <= 1'b0;
      oob_flag <= 1'b0;
    end else begin
      wrEn     <= pixIf.plot && inRange;
      oob_flag <= oob_flag | (pixIf.plot & ~inRange);
    end
    wrAddr <= plotAddr;
    wrData <= pixIf.colour;
  end

  // Read-before-write: a same-edge read of the address being written returns old data
  always_ff @(posedge clock) begin
    if (wrEn) frameBuf[wrAddr] <= wrData;
    if (visible) rdData <= frameBuf[rdAddr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pixEn       <= 1'b0;
      hCnt        <= '0;
      vCnt        <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      pixEn       <= ~pixEn;
      frame_start <= pixEn && (hCnt == H_MAX) && (vCnt == V_MAX);
      if (pixEn) begin
        // rdData was fetched on the preceding clock for this same (h,v)
        vga_hs      <= !((hCnt >= H_SYNC_BEG) && (hCnt <= H_SYNC_END));
        vga_vs      <= !((vCnt >= V_SYNC_BEG) && (vCnt <= V_SYNC_END));
        vga_blank_n <= visible;
        vga_r       <= visible ? {8{rdData[2]}} : 8'h00;
        vga_g       <= visible ? {8{rdData[1]}} : 8'h00;
        vga_b       <= visible ? {8{rdData[0]}} : 8'h00;
        if (hCnt == H_MAX) begin
          hCnt <= '0;
          vCnt <= (vCnt == V_MAX) ? 10'd0 : vCnt + 10'd1;
        end else begin
          hCnt <= hCnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink: cycle-count scan model plus a raster-ordered pixel scoreboard.
module tb_vga_pixel_sink;
  logic clock = 1'b0;
  logic reset = 1'b1;
  vga_pixel_sink_if pixIf ();
  logic oob_flag, frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_pixel_sink dut (
    .clock(clock), .reset(reset), .pixIf(pixIf),
    .oob_flag(oob_flag), .frame_start(frame_start), .vga_clk(vga_clk),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #10 clock = ~clock;

  localparam int FRAME_CLKS = 840000;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    longint     key;
    int         ep, fr, sx, sy;
    logic [23:0] rgb;
  } exp_t;
  exp_t sbq[$];
  int   fsQ[$];

  int   epoch = 0;
  logic monOn = 1'b0;
  int   syncErr = 0;
  int   firstErr = -1;
  int   hsLow = 0, vsLow = 0, blankHigh = 0;

  function automatic longint pix_key(int ep, int fr, int sx, int sy);
    return ((longint'(ep) * 4 + longint'(fr)) * 525 + longint'(sy)) * 800 + longint'(sx);
  endfunction

  task automatic push_exp(int ep, int fr, int sx, int sy, logic [2:0] c);
    exp_t e;
    int idx;
    e.key = pix_key(ep, fr, sx, sy);
    e.ep = ep; e.fr = fr; e.sx = sx; e.sy = sy;
    e.rgb = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    idx = sbq.size();
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].key > e.key) begin
        idx = i;
        break;
      end
    end
    if (idx == sbq.size()) sbq.push_back(e);
    else sbq.insert(idx, e);
  endtask

  task automatic monitor();
    int n, p, h, v, fr;
    logic eHs, eVs, eBlank, eFs;
    longint key;
    exp_t e;
    n = int'(cyc);
    h = 0; v = 0; fr = 0;
    eFs = (n != 0) && ((n % FRAME_CLKS) == 0);
    if (n < 2) begin
      eHs = 1'b1; eVs = 1'b1; eBlank = 1'b0;
    end else begin
      p  = ((n - 2) / 2) % (FRAME_CLKS / 2);
      fr = (n - 2) / FRAME_CLKS;
      h  = p % 800;
      v  = p / 800;
      eHs    = !(h >= 656 && h <= 751);
      eVs    = !(v >= 490 && v <= 491);
      eBlank = (h < 640) && (v < 480);
    end
    if (vga_hs !== eHs || vga_vs !== eVs || vga_blank_n !== eBlank || frame_start !== eFs ||
        vga_clk !== n[0] || vga_sync_n !== 1'b0 ||
        (!eBlank && {vga_r, vga_g, vga_b} !== 24'h0)) begin
      if (syncErr == 0) firstErr = n;
      syncErr++;
    end
    if (epoch == 1 && n >= 2 && n < 2 + 2 * FRAME_CLKS) begin
      if (vga_hs === 1'b0) hsLow++;
      if (vga_vs === 1'b0) vsLow++;
      if (vga_blank_n === 1'b1) blankHigh++;
    end
    if (epoch == 1 && frame_start === 1'b1) fsQ.push_back(n);
    if (n >= 2 && n[0] == 1'b0) begin
      key = pix_key(epoch, fr, h, v);
      while (sbq.size() > 0 && sbq[0].key < key) begin
        e = sbq.pop_front();
        tests++; fails++;
        $display("FAIL pixel_missed ep%0d fr%0d (%0d,%0d): actual not observed, required rgb %06h",
                 e.ep, e.fr, e.sx, e.sy, e.rgb);
      end
      if (sbq.size() > 0 && sbq[0].key == key) begin
        e = sbq.pop_front();
        tests++;
        if ({vga_r, vga_g, vga_b} !== e.rgb || vga_blank_n !== 1'b1) begin
          fails++;
          $display("FAIL pixel ep%0d fr%0d (%0d,%0d): actual rgb %06h blank_n %b, required rgb %06h blank_n 1",
                   e.ep, e.fr, e.sx, e.sy, {vga_r, vga_g, vga_b}, vga_blank_n, e.rgb);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (monOn) monitor();
  endtask

  task automatic run_until(int target);
    int guard = 0;
    while (int'(cyc) < target && guard < 3000000) begin
      step();
      guard++;
    end
    tests++;
    if (int'(cyc) != target) begin
      fails++;
      $display("FAIL run_until: actual cycle %0d, required %0d", cyc, target);
    end
  endtask

  task automatic plot_px(int px, int py, logic [2:0] c);
    pixIf.plot = 1'b1; pixIf.x = 9'(px); pixIf.y = 8'(py); pixIf.colour = c;
    step();
    pixIf.plot = 1'b0;
  endtask

  task automatic test_reset();
    pixIf.plot = 1'b0; pixIf.x = '0; pixIf.y = '0; pixIf.colour = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests += 8;
    if (vga_hs !== 1'b1)      begin fails++; $display("FAIL reset_hs: actual %b, required 1", vga_hs); end
    if (vga_vs !== 1'b1)      begin fails++; $display("FAIL reset_vs: actual %b, required 1", vga_vs); end
    if (vga_blank_n !== 1'b0) begin fails++; $display("FAIL reset_blank_n: actual %b, required 0", vga_blank_n); end
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin fails++; $display("FAIL reset_rgb: actual %06h, required 000000", {vga_r, vga_g, vga_b}); end
    if (oob_flag !== 1'b0)    begin fails++; $display("FAIL reset_oob: actual %b, required 0", oob_flag); end
    if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start: actual %b, required 0", frame_start); end
    if (vga_clk !== 1'b0)     begin fails++; $display("FAIL reset_vga_clk: actual %b, required 0", vga_clk); end
    if (vga_sync_n !== 1'b0)  begin fails++; $display("FAIL reset_sync_n: actual %b, required 0", vga_sync_n); end
    monOn = 1'b1;
    reset = 1'b0;
  endtask

  task automatic test_out_of_range();
    plot_px(0, 11, 3'b010);
    push_exp(0, 0, 0, 22, 3'b010); push_exp(0, 0, 1, 23, 3'b010);
    push_exp(1, 0, 0, 22, 3'b010);
    tests++;
    if (oob_flag !== 1'b0) begin fails++; $display("FAIL oob_before: actual %b, required 0", oob_flag); end
    plot_px(320, 10, 3'b111);
    tests++;
    if (oob_flag !== 1'b1) begin fails++; $display("FAIL oob_next_clock: actual %b, required 1", oob_flag); end
  endtask

  task automatic test_corner_writes();
    plot_px(0, 0, 3'b100);
    plot_px(319, 239, 3'b011);
    plot_px(160, 120, 3'b111);
    plot_px(1, 0, 3'b010);
    push_exp(1, 0, 0, 0, 3'b100);     push_exp(1, 0, 1, 1, 3'b100);
    push_exp(1, 0, 2, 0, 3'b010);     push_exp(1, 0, 3, 1, 3'b010);
    push_exp(1, 0, 320, 240, 3'b111); push_exp(1, 0, 321, 241, 3'b111);
    push_exp(1, 0, 638, 478, 3'b011); push_exp(1, 0, 639, 479, 3'b011);
    push_exp(1, 1, 0, 0, 3'b100);     push_exp(1, 1, 639, 479, 3'b011);
    plot_px(100, 50, 3'b110);
  endtask

  task automatic test_burst();
    for (int i = 0; i < 240; i++) begin
      pixIf.plot = 1'b1; pixIf.x = 9'(i); pixIf.y = 8'd60; pixIf.colour = 3'b001;
      push_exp(0, 0, 2 * i, 120, 3'b001);
      push_exp(0, 0, 2 * i + 1, 121, 3'b001);
      push_exp(1, 0, 2 * i, 120, 3'b001);
      step();
    end
    pixIf.plot = 1'b0;
  endtask

  // The write lands on the same edge that fetches screen pixel (200,100)
  task automatic test_collision();
    push_exp(0, 0, 200, 100, 3'b110);
    push_exp(0, 0, 201, 100, 3'b101);
    push_exp(0, 0, 200, 101, 3'b101);
    push_exp(1, 0, 200, 100, 3'b101);
    run_until(2 * (100 * 800 + 200) - 1);
    plot_px(100, 50, 3'b101);
  endtask

  task automatic test_mid_reset();
    run_until(2 + 2 * (200 * 800) + 10);
    tests++;
    if (oob_flag !== 1'b1) begin fails++; $display("FAIL oob_sticky: actual %b, required 1", oob_flag); end
    reset = 1'b1;
    step(); step();
    tests += 2;
    if (vga_blank_n !== 1'b0) begin fails++; $display("FAIL midreset_blank_n: actual %b, required 0", vga_blank_n); end
    if (oob_flag !== 1'b0)    begin fails++; $display("FAIL midreset_oob_clear: actual %b, required 0", oob_flag); end
    epoch = 1;
    reset = 1'b0;
    step(); step();
    tests++;
    if (vga_blank_n !== 1'b1) begin fails++; $display("FAIL midreset_restart_blank_n: actual %b, required 1", vga_blank_n); end
  endtask

  task automatic test_sync_timing();
    run_until(2 + 2 * FRAME_CLKS + 2);
    tests += 5;
    if (hsLow !== 192 * 525 * 2) begin fails++; $display("FAIL hs_low_clocks: actual %0d, required %0d", hsLow, 192 * 525 * 2); end
    if (vsLow !== 3200 * 2)      begin fails++; $display("FAIL vs_low_clocks: actual %0d, required %0d", vsLow, 3200 * 2); end
    if (blankHigh !== 1280 * 480 * 2) begin fails++; $display("FAIL blank_high_clocks: actual %0d, required %0d", blankHigh, 1280 * 480 * 2); end
    if (syncErr !== 0) begin fails++; $display("FAIL scan_model: actual %0d bad cycles (first at %0d), required 0", syncErr, firstErr); end
    if (fsQ.size() != 2) begin
      fails++; $display("FAIL frame_start_count: actual %0d, required 2", fsQ.size());
    end else begin
      tests += 2;
      if (fsQ[0] != FRAME_CLKS) begin fails++; $display("FAIL frame_start_first: actual %0d, required %0d", fsQ[0], FRAME_CLKS); end
      if (fsQ[1] - fsQ[0] != FRAME_CLKS) begin fails++; $display("FAIL frame_start_spacing: actual %0d, required %0d", fsQ[1] - fsQ[0], FRAME_CLKS); end
    end
  endtask

  task automatic test_scoreboard_drained();
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drained: actual %0d pending, required 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_out_of_range();
    test_corner_writes();
    test_burst();
    test_collision();
    test_mid_reset();
    test_sync_timing();
    test_scoreboard_drained();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
